// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing one-hot-or-zero enables for the shared data-bus tri-state drivers.
// Optional macro BUS_ARB_TURNAROUND_EN inserts one all-zero enable cycle (TURN) after every release.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 4,
    parameter int OWN_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] en,
    output logic [OWN_W-1:0] owner,
    output logic             busy,
    output logic             handover
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [OWN_W-1:0] PTR_RST  = OWN_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t           state;
    logic [HW-1:0]    hold_cnt;
    logic [OWN_W-1:0] rr_ptr;

    logic [N_REQ-1:0] owner_mask;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] win_onehot;
    logic [OWN_W-1:0] win_idx;
    logic             win_found;
    logic             hold_full;
    logic             rel_own;

    assign owner_mask = ONE << owner;
    assign hold_full  = (hold_cnt == HOLD_MAX);
    assign rel_own    = !req[owner] || (hold_full && (|(req & ~owner_mask)));
    // While owning, the current owner is excluded so a release hands to someone else.
    assign arb_req    = (state == OWN) ? (req & ~owner_mask) : req;

    // Rotate so bit 0 of rot is requester rr_ptr+1, then take the first set bit.
    always_comb begin
        rot       = N_REQ'(({arb_req, arb_req} >> 1) >> rr_ptr);
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && rot[i]) begin
                win_found = 1'b1;
                win_idx   = OWN_W'((int'(rr_ptr) + 1 + i) % N_REQ);
            end
        end
        win_onehot = ONE << win_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            en       <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            handover <= 1'b0;
            hold_cnt <= '0;
            rr_ptr   <= PTR_RST;
        end else begin
            handover <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (win_found) begin
                        state    <= OWN;
                        en       <= win_onehot;
                        owner    <= win_idx;
                        rr_ptr   <= win_idx;
                        hold_cnt <= HW'(1);
                        busy     <= 1'b1;
                        handover <= 1'b1;
                    end else begin
                        state <= IDLE;
                        en    <= '0;
                        busy  <= 1'b0;
                    end
                end
                OWN: begin
                    if (!rel_own) begin
                        if (!hold_full) hold_cnt <= hold_cnt + 1'b1;
                    end else begin
`ifdef BUS_ARB_TURNAROUND_EN
                        state <= TURN;
                        en    <= '0;
                        busy  <= 1'b0;
`else
                        if (win_found) begin
                            state    <= OWN;
                            en       <= win_onehot;
                            owner    <= win_idx;
                            rr_ptr   <= win_idx;
                            hold_cnt <= HW'(1);
                            busy     <= 1'b1;
                            handover <= 1'b1;
                        end else begin
                            state <= IDLE;
                            en    <= '0;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    en    <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
